// File: rtl/cell_sram_writer_pkg.sv
// Console geometry and writer state encoding shared by the text renderer,
// the cell SRAM writer and the VGA reader.
package cell_sram_writer_pkg;

    localparam int CONSOLE_LINES        = 24;
    localparam int CONSOLE_COLUMNS      = 80;
    localparam int HEIGHT_PER_CHARACTER = 20;
    localparam int WIDTH_PER_CHARACTER  = 8;
    localparam int SCREEN_WIDTH         = 640;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_WRITE = 2'd1,
        WR_DONE  = 2'd2
    } writer_state_e;

endpackage

// File: rtl/cell_sram_writer.sv
// Writes one shaped character cell into the SRAM framebuffer, one word per pixel.
// Optional macro CELL_WRITER_PERF_COUNTER_EN adds a 32-bit acked-pixel counter output.
module cell_sram_writer
    import cell_sram_writer_pkg::*;
#(
    parameter int CONSOLE_LINES        = cell_sram_writer_pkg::CONSOLE_LINES,
    parameter int CONSOLE_COLUMNS      = cell_sram_writer_pkg::CONSOLE_COLUMNS,
    parameter int HEIGHT_PER_CHARACTER = cell_sram_writer_pkg::HEIGHT_PER_CHARACTER,
    parameter int WIDTH_PER_CHARACTER  = cell_sram_writer_pkg::WIDTH_PER_CHARACTER,
    parameter int SCREEN_WIDTH         = cell_sram_writer_pkg::SCREEN_WIDTH,
    parameter int SRAM_ADDR_WIDTH      = 20,
    parameter int SRAM_DATA_WIDTH      = 16
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           cell_valid,
    output logic                                           cell_ready,
    input  logic [4:0]                                     cell_line,
    input  logic [6:0]                                     cell_column,
    input  logic [HEIGHT_PER_CHARACTER*WIDTH_PER_CHARACTER-1:0] cell_r,
    input  logic [HEIGHT_PER_CHARACTER*WIDTH_PER_CHARACTER-1:0] cell_g,
    input  logic [HEIGHT_PER_CHARACTER*WIDTH_PER_CHARACTER-1:0] cell_b,
    output logic                                           cell_done,
    output logic                                           cell_error,
    output logic                                           sram_req,
    output logic [SRAM_ADDR_WIDTH-1:0]                     sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0]                     sram_data,
`ifdef CELL_WRITER_PERF_COUNTER_EN
    output logic [31:0]                                    perf_pixel_count,
`endif
    input  logic                                           sram_ack
);

    localparam int PIX = HEIGHT_PER_CHARACTER * WIDTH_PER_CHARACTER;
    localparam int XW  = (WIDTH_PER_CHARACTER > 1) ? $clog2(WIDTH_PER_CHARACTER) : 1;
    localparam int YW  = (HEIGHT_PER_CHARACTER > 1) ? $clog2(HEIGHT_PER_CHARACTER) : 1;
    localparam int IW  = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int AW  = SRAM_ADDR_WIDTH;

    localparam logic [1:0] IDLE  = WR_IDLE;
    localparam logic [1:0] WRITE = WR_WRITE;
    localparam logic [1:0] DONE  = WR_DONE;

    localparam logic [XW-1:0] X_LAST      = XW'(WIDTH_PER_CHARACTER - 1);
    localparam logic [YW-1:0] Y_LAST      = YW'(HEIGHT_PER_CHARACTER - 1);
    localparam logic [AW-1:0] LINE_STRIDE = AW'(HEIGHT_PER_CHARACTER * SCREEN_WIDTH);
    localparam logic [AW-1:0] COL_STRIDE  = AW'(WIDTH_PER_CHARACTER);
    // Moving from the last pixel of one cell row to the first of the next.
    localparam logic [AW-1:0] ROW_STEP    = AW'(SCREEN_WIDTH - (WIDTH_PER_CHARACTER - 1));

    logic [1:0]     state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           err_q, err_d;
    logic [PIX-1:0] pix_r_q, pix_r_d;
    logic [PIX-1:0] pix_g_q, pix_g_d;
    logic [PIX-1:0] pix_b_q, pix_b_d;
    logic [IW-1:0]  pix_idx;

`ifdef CELL_WRITER_PERF_COUNTER_EN
    logic [31:0]    perf_q, perf_d;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        err_d   = err_q;
        pix_r_d = pix_r_q;
        pix_g_d = pix_g_q;
        pix_b_d = pix_b_q;
`ifdef CELL_WRITER_PERF_COUNTER_EN
        perf_d  = perf_q;
        if (state_q == WRITE && sram_ack) perf_d = perf_q + 32'd1;
`endif
        case (state_q)
            IDLE: begin
                if (cell_valid) begin
                    pix_r_d = cell_r;
                    pix_g_d = cell_g;
                    pix_b_d = cell_b;
                    x_d     = '0;
                    y_d     = '0;
                    if (int'(cell_line) >= CONSOLE_LINES ||
                        int'(cell_column) >= CONSOLE_COLUMNS) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        addr_d  = AW'(cell_line) * LINE_STRIDE + AW'(cell_column) * COL_STRIDE;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (sram_ack) begin
                    if (x_q != X_LAST) begin
                        x_d    = x_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end else if (y_q != Y_LAST) begin
                        x_d    = '0;
                        y_d    = y_q + 1'b1;
                        addr_d = addr_q + ROW_STEP;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
`ifdef CELL_WRITER_PERF_COUNTER_EN
            perf_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
`ifdef CELL_WRITER_PERF_COUNTER_EN
            perf_q  <= perf_d;
`endif
        end
    end

    // Pixel bits are pure payload; sram_data is gated so they need no reset.
    always_ff @(posedge clk) begin
        pix_r_q <= pix_r_d;
        pix_g_q <= pix_g_d;
        pix_b_q <= pix_b_d;
    end

    assign pix_idx = IW'(y_q) * IW'(WIDTH_PER_CHARACTER) + IW'(x_q);

    always_comb begin
        sram_data = '0;
        if (state_q == WRITE) sram_data[2:0] = {pix_r_q[pix_idx], pix_g_q[pix_idx], pix_b_q[pix_idx]};
    end

    assign cell_ready = (state_q == IDLE);
    assign sram_req   = (state_q == WRITE);
    assign sram_addr  = addr_q;
    assign cell_done  = (state_q == DONE);
    assign cell_error = (state_q == DONE) && err_q;

`ifdef CELL_WRITER_PERF_COUNTER_EN
    assign perf_pixel_count = perf_q;
`endif

endmodule

// File: tb/tb_cell_sram_writer.sv
// Directed bench for cell_sram_writer: full cells, stalled acks, dropped cells, mid-cell reset.
module tb_cell_sram_writer;

    localparam int H   = 20;
    localparam int W   = 8;
    localparam int SW  = 640;
    localparam int PIX = H * W;

    logic           clk = 1'b0;
    logic           rst;
    logic           cell_valid;
    logic           cell_ready;
    logic [4:0]     cell_line;
    logic [6:0]     cell_column;
    logic [PIX-1:0] cell_r, cell_g, cell_b;
    logic           cell_done, cell_error;
    logic           sram_req;
    logic [19:0]    sram_addr;
    logic [15:0]    sram_data;
    logic           sram_ack;
`ifdef CELL_WRITER_PERF_COUNTER_EN
    logic [31:0]    perf_pixel_count;
`endif

    int vectors    = 0;
    int miscompares = 0;

    logic [PIX-1:0] ones, zeros, pat_r, pat_g, pat_b;

    cell_sram_writer dut (
        .clk         (clk),
        .rst         (rst),
        .cell_valid  (cell_valid),
        .cell_ready  (cell_ready),
        .cell_line   (cell_line),
        .cell_column (cell_column),
        .cell_r      (cell_r),
        .cell_g      (cell_g),
        .cell_b      (cell_b),
        .cell_done   (cell_done),
        .cell_error  (cell_error),
        .sram_req    (sram_req),
        .sram_addr   (sram_addr),
        .sram_data   (sram_data),
`ifdef CELL_WRITER_PERF_COUNTER_EN
        .perf_pixel_count (perf_pixel_count),
`endif
        .sram_ack    (sram_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offers a cell, acks every 'period'-th cycle, and checks each word and the done pulse.
    // cell_valid stays high through the write to show it is ignored while busy.
    task automatic run_cell(input int line, input int col,
                            input logic [PIX-1:0] r, input logic [PIX-1:0] g,
                            input logic [PIX-1:0] b, input int period, input int base);
        int p;
        int c;
        int idx;
        int exp_addr;
        logic [2:0] exp_data;
        cell_line   = 5'(line);
        cell_column = 7'(col);
        cell_r      = r;
        cell_g      = g;
        cell_b      = b;
        cell_valid  = 1'b1;
        sram_ack    = 1'b0;
        check($sformatf("ready_before_%0d_%0d", line, col), 32'(cell_ready), 32'd1);
        tick();
        cell_valid = (period > 1);
        p = 0;
        c = 0;
        while (p < PIX && c < 2000) begin
            sram_ack = ((c % period) == (period - 1));
            idx      = (p / W) * W + (p % W);
            exp_addr = base + (p / W) * SW + (p % W);
            exp_data = {r[idx], g[idx], b[idx]};
            check($sformatf("req_c%0d_p%0d", c, p), 32'(sram_req), 32'd1);
            check($sformatf("ready_busy_p%0d", p), 32'(cell_ready), 32'd0);
            check($sformatf("addr_p%0d", p), 32'(sram_addr), 32'(exp_addr));
            check($sformatf("data_p%0d", p), 32'(sram_data), 32'(exp_data));
            check($sformatf("nodone_p%0d", p), 32'(cell_done), 32'd0);
            if (sram_ack) p++;
            c++;
            tick();
        end
        if (p < PIX) check("write_timeout", 32'(p), 32'(PIX));
        sram_ack   = 1'b0;
        cell_valid = 1'b0;
        check("done_pulse", 32'(cell_done), 32'd1);
        check("done_error", 32'(cell_error), 32'd0);
        check("done_req", 32'(sram_req), 32'd0);
        check("done_ready", 32'(cell_ready), 32'd0);
        tick();
        check("after_done", 32'(cell_done), 32'd0);
        check("after_ready", 32'(cell_ready), 32'd1);
        check("after_req", 32'(sram_req), 32'd0);
    endtask

    task automatic drop_cell(input int line, input int col);
        cell_line   = 5'(line);
        cell_column = 7'(col);
        cell_r      = ones;
        cell_g      = ones;
        cell_b      = ones;
        cell_valid  = 1'b1;
        sram_ack    = 1'b1;
        tick();
        cell_valid = 1'b0;
        check($sformatf("drop_done_%0d_%0d", line, col), 32'(cell_done), 32'd1);
        check($sformatf("drop_error_%0d_%0d", line, col), 32'(cell_error), 32'd1);
        check("drop_req", 32'(sram_req), 32'd0);
        check("drop_ready", 32'(cell_ready), 32'd0);
        tick();
        check("drop_after_done", 32'(cell_done), 32'd0);
        check("drop_after_error", 32'(cell_error), 32'd0);
        check("drop_after_req", 32'(sram_req), 32'd0);
        check("drop_after_ready", 32'(cell_ready), 32'd1);
        sram_ack = 1'b0;
    endtask

    initial begin
        ones  = '1;
        zeros = '0;
        for (int i = 0; i < PIX; i++) begin
            pat_r[i] = ((i % 3) == 0);
            pat_g[i] = ((i % 5) == 1);
            pat_b[i] = (((i / W) % 2) == 1);
        end

        rst         = 1'b0;
        cell_valid  = 1'b0;
        cell_line   = '0;
        cell_column = '0;
        cell_r      = '0;
        cell_g      = '0;
        cell_b      = '0;
        sram_ack    = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(cell_ready), 32'd1);
        check("rst_req", 32'(sram_req), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_data", 32'(sram_data), 32'd0);
        check("rst_done", 32'(cell_done), 32'd0);
        check("rst_error", 32'(cell_error), 32'd0);
        rst = 1'b1;
        tick();

        // Cell (0,0), red only: words 0..7, 640..647, ..., 12160..12167 all 0x0004.
        run_cell(0, 0, ones, zeros, zeros, 1, 0);
        // Cell (23,79), white: base 23*12800 + 79*8 = 295032, last word 307199.
        run_cell(23, 79, ones, ones, ones, 1, 295032);
        drop_cell(24, 0);
`ifdef CELL_WRITER_PERF_COUNTER_EN
        check("perf_count", perf_pixel_count, 32'd320);
`endif
        // Cell (5,10), mixed pattern, ack every 4th cycle: base 64000 + 80 = 64080.
        run_cell(5, 10, pat_r, pat_g, pat_b, 4, 64080);
        drop_cell(0, 80);

        // Reset after 50 acked pixels of cell (3,4).
        cell_line   = 5'd3;
        cell_column = 7'd4;
        cell_r      = ones;
        cell_g      = zeros;
        cell_b      = ones;
        cell_valid  = 1'b1;
        tick();
        cell_valid = 1'b0;
        sram_ack   = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        check("pre_rst_addr", 32'(sram_addr), 32'(38400 + 32 + 6 * SW + 2));
        sram_ack = 1'b0;
        rst      = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_req", 32'(sram_req), 32'd0);
        check("midrst_ready", 32'(cell_ready), 32'd1);
        check("midrst_done", 32'(cell_done), 32'd0);
        check("midrst_addr", 32'(sram_addr), 32'd0);
        tick();
        check("midrst_done2", 32'(cell_done), 32'd0);
        check("midrst_req2", 32'(sram_req), 32'd0);

        // Cell (1,2) after the abandoned one: base 12800 + 16 = 12816.
        run_cell(1, 2, pat_g, pat_b, pat_r, 1, 12816);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
